// File: rtl/m68k_pkg.sv
// Shared definitions for the 68000 interrupt sequencer: register map,
// IACK state encoding, vector constants and the priority encoder.
package m68k_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CFG  = 2'd3;

  // 68000 autovector numbers start at 24 (level 1 -> 25 ... level 7 -> 31).
  localparam logic [7:0] AUTOVEC_BASE         = 8'd24;
  localparam logic [7:0] SPURIOUS_VEC_DEFAULT = 8'd24;
  localparam logic [7:0] VBASE_RESET          = 8'h40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACK   = 2'd2
  } iack_state_e;

  // Highest set bit index + 1, or 0 when nothing is set (bit n = level n+1).
  function automatic logic [2:0] prio_level(input logic [6:0] req);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (req[i]) lvl = 3'(i + 1);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser chain followed by a rising-edge detector.
// sync_o is the last synchroniser stage; rise_o is high for the one cycle
// in which sync_o is high and its previous value was low.
// SYNC_STAGES must be at least 2.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 7
) (
  input  logic             wb_clk_i,
  input  logic             wb_reset_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      logic [SYNC_STAGES-1:0] chain_reg;
      logic                   prev_reg;

      // Shift the raw request through the synchroniser and remember last output.
      always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
          chain_reg <= '0;
          prev_reg  <= 1'b0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_i[gi]};
          prev_reg  <= chain_reg[SYNC_STAGES-1];
        end
      end

      assign sync_o[gi] = chain_reg[SYNC_STAGES-1];
      assign rise_o[gi] = chain_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/m68k_irq_vector_ctrl.sv
// Interrupt sequencer for a 68000: synchronises seven request lines, keeps
// pending/mask/trigger-mode state, drives the encoded IPL and answers the
// CPU interrupt-acknowledge cycle with a vector number.
module m68k_irq_vector_ctrl
  import m68k_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] SPURIOUS_VEC = SPURIOUS_VEC_DEFAULT
) (
  input  logic       wb_clk_i,
  input  logic       wb_reset_i,
  input  logic [6:0] int_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [1:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  input  logic       iack_i,
  input  logic [2:0] iack_level_i,
  output logic       iack_ack_o,
  output logic [7:0] vector_o,
  output logic [2:0] ipl_o
);

  logic [6:0]  sync_s, sync_rise;
  logic [6:0]  pend_reg, mask_reg, edge_reg, pend_next;
  logic [4:0]  vbase_reg;
  logic        autovec_reg;
  logic        ack_reg;
  logic [7:0]  dat_reg, rd_data;
  logic [2:0]  ipl_reg;
  iack_state_e state_reg;
  logic [2:0]  lvl_reg;
  logic [7:0]  vector_reg, vec_next;
  logic        iack_ack_reg;

  logic        wb_access;
  logic [6:0]  sw_clr, iack_clr, eff;
  logic [7:0]  lvl_onehot;
  logic        lvl_hit;
  logic        unused_bits;

  irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(7)) u_sync (
    .wb_clk_i  (wb_clk_i),
    .wb_reset_i(wb_reset_i),
    .async_i   (int_i),
    .sync_o    (sync_s),
    .rise_o    (sync_rise)
  );

  // A new access is accepted only while ack is low, giving 2-cycle transfers.
  assign wb_access  = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign sw_clr     = (wb_access && wb_we_i && wb_adr_i == REG_PEND) ? (wb_dat_i[6:0] & edge_reg) : 7'd0;
  assign eff        = pend_reg & mask_reg;
  assign lvl_onehot = 8'd1 << lvl_reg;
  assign lvl_hit    = |(lvl_onehot[7:1] & eff);
  // Service clears only edge-mode requests; level sources stay until released.
  assign iack_clr   = (state_reg == LATCH && lvl_hit) ? (lvl_onehot[7:1] & edge_reg) : 7'd0;
  // Edge bits: set beats clear in the same cycle. Level bits follow the line.
  assign pend_next  = (edge_reg & ((pend_reg & ~(sw_clr | iack_clr)) | sync_rise)) | (~edge_reg & sync_s);
  assign unused_bits = ^{wb_dat_i[2:1], lvl_onehot[0]};

  // Register read multiplexer.
  always_comb begin
    rd_data = 8'd0;
    case (wb_adr_i)
      REG_PEND: rd_data = {1'b0, pend_reg};
      REG_MASK: rd_data = {1'b0, mask_reg};
      REG_EDGE: rd_data = {1'b0, edge_reg};
      default:  rd_data = {vbase_reg, 2'b00, autovec_reg};
    endcase
  end

  // Vector selection for the level latched at the start of the IACK cycle.
  always_comb begin
    vec_next = SPURIOUS_VEC;
    if (lvl_hit) begin
      vec_next = autovec_reg ? (AUTOVEC_BASE + {5'd0, lvl_reg}) : {vbase_reg, lvl_reg};
    end
  end

  // Wishbone slave: single-cycle ack pulse, registered read data, config writes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      ack_reg     <= 1'b0;
      dat_reg     <= 8'd0;
      mask_reg    <= 7'd0;
      edge_reg    <= 7'd0;
      vbase_reg   <= VBASE_RESET[7:3];
      autovec_reg <= 1'b0;
    end else begin
      ack_reg <= wb_access;
      if (wb_access) begin
        dat_reg <= rd_data;
        if (wb_we_i) begin
          case (wb_adr_i)
            REG_MASK: mask_reg <= wb_dat_i[6:0];
            REG_EDGE: edge_reg <= wb_dat_i[6:0];
            REG_CFG: begin
              vbase_reg   <= wb_dat_i[7:3];
              autovec_reg <= wb_dat_i[0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Pending state and the registered priority code to the CPU.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      pend_reg <= 7'd0;
      ipl_reg  <= 3'd0;
    end else begin
      pend_reg <= pend_next;
      ipl_reg  <= prio_level(eff);
    end
  end

  // IACK sequencer: latch level, choose vector, hold it until IACK ends.
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_reg    <= IDLE;
      lvl_reg      <= 3'd0;
      vector_reg   <= 8'd0;
      iack_ack_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (iack_i) begin
            lvl_reg   <= iack_level_i;
            state_reg <= LATCH;
          end
        end
        LATCH: begin
          vector_reg   <= vec_next;
          iack_ack_reg <= 1'b1;
          state_reg    <= ACK;
        end
        ACK: begin
          if (!iack_i) begin
            iack_ack_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: begin
          iack_ack_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign wb_dat_o   = dat_reg;
  assign wb_ack_o   = ack_reg;
  assign iack_ack_o = iack_ack_reg;
  assign vector_o   = vector_reg;
  assign ipl_o      = ipl_reg;

endmodule

// File: tb/tb_m68k_irq_vector_ctrl.sv
// Self-checking bench for m68k_irq_vector_ctrl: table-driven IACK vectors,
// directed multi-cycle sequences and randomized traffic against a model.
module tb_m68k_irq_vector_ctrl;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst;
  logic [6:0] int_i;
  logic       wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       iack_i;
  logic [2:0] iack_level_i;
  logic       iack_ack_o;
  logic [7:0] vector_o;
  logic [2:0] ipl_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] int_val;
    logic [6:0] mask_val;
    logic [7:0] cfg;
    logic [2:0] lvl;
    logic [2:0] exp_ipl;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t tbl[8];

  m68k_irq_vector_ctrl #(.SYNC_STAGES(SYNC), .SPURIOUS_VEC(8'd24)) dut (
    .wb_clk_i    (clk),
    .wb_reset_i  (rst),
    .int_i       (int_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .iack_i      (iack_i),
    .iack_level_i(iack_level_i),
    .iack_ack_o  (iack_ack_o),
    .vector_o    (vector_o),
    .ipl_o       (ipl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference rules: highest pending-and-enabled level, and vector choice.
  function automatic int model_ipl(input int eff);
    for (int l = 7; l >= 1; l--) if (((eff >> (l - 1)) & 1) != 0) return l;
    return 0;
  endfunction

  function automatic int model_vec(input int eff, input int lvl, input int cfg);
    if (lvl == 0 || ((eff >> (lvl - 1)) & 1) == 0) return 24;
    if ((cfg & 1) != 0) return 24 + lvl;
    return (cfg & 'hF8) + lvl;
  endfunction

  task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wdat,
                         output logic [7:0] rdat);
    bit got;
    got  = 1'b0;
    rdat = 8'd0;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got  = 1'b1;
        rdat = wb_dat_o;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("wb_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [7:0] d);
    logic [7:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [7:0] d);
    wb_xfer(1'b0, adr, 8'd0, d);
  endtask

  task automatic iack_start(input logic [2:0] lvl, output int delay, output logic [7:0] vec);
    delay = -1;
    vec   = 8'd0;
    @(negedge clk);
    iack_i = 1'b1; iack_level_i = lvl;
    for (int c = 1; c <= 6 && delay < 0; c++) begin
      @(posedge clk); #1;
      if (iack_ack_o) begin
        delay = c;
        vec   = vector_o;
      end
    end
  endtask

  task automatic iack_end();
    bit dropped;
    dropped = 1'b0;
    @(negedge clk);
    iack_i = 1'b0;
    for (int c = 1; c <= 4 && !dropped; c++) begin
      @(posedge clk); #1;
      if (!iack_ack_o) dropped = 1'b1;
    end
    check("iack_ack_drop", 32'(dropped), 32'd1);
  endtask

  task automatic pulse_int(input logic [6:0] p);
    @(negedge clk); int_i = p;
    @(negedge clk); int_i = 7'd0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] rd, vec, cfg;
  int         delay, lat, mdl_pend, lvl, ival, mval, clr;

  initial begin
    tbl[0] = '{7'h14, 7'h7F, 8'h40, 3'd5, 3'd5, 8'h45};
    tbl[1] = '{7'h14, 7'h6F, 8'h40, 3'd3, 3'd3, 8'h43};
    tbl[2] = '{7'h14, 7'h7F, 8'h81, 3'd3, 3'd5, 8'd27};
    tbl[3] = '{7'h00, 7'h7F, 8'h81, 3'd3, 3'd0, 8'd24};
    tbl[4] = '{7'h7F, 7'h00, 8'h40, 3'd7, 3'd0, 8'd24};
    tbl[5] = '{7'h40, 7'h7F, 8'hF8, 3'd7, 3'd7, 8'hFF};
    tbl[6] = '{7'h01, 7'h01, 8'h40, 3'd0, 3'd1, 8'd24};
    tbl[7] = '{7'h01, 7'h01, 8'hA8, 3'd1, 3'd1, 8'hA9};

    rst = 1'b1; int_i = 7'd0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 2'd0; wb_dat_i = 8'd0; iack_i = 1'b0; iack_level_i = 3'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ipl", ipl_o, 0);
    check("rst_iack_ack", iack_ack_o, 0);
    check("rst_vector", vector_o, 0);
    check("rst_wb_ack", wb_ack_o, 0);
    check("rst_wb_dat", wb_dat_o, 0);
    @(negedge clk); rst = 1'b0;
    wb_read(2'd0, rd); check("rst_pend", rd, 8'h00);
    wb_read(2'd1, rd); check("rst_mask", rd, 8'h00);
    wb_read(2'd2, rd); check("rst_edge", rd, 8'h00);
    wb_read(2'd3, rd); check("rst_cfg", rd, 8'h40);
    $display("txn reset checks done");

    // Level mode latency and priority
    wb_write(2'd1, 8'h7F);
    wb_read(2'd1, rd); check("mask_rb_bit7_zero", rd, 8'h7F);
    @(negedge clk); int_i = 7'h14;
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ipl_o == 3'd5) lat = c;
    end
    check("ipl_latency", lat, SYNC + 2);
    @(negedge clk); int_i = 7'h04;
    wait_cycles(6);
    check("ipl_after_clear_bit4", ipl_o, 3);
    $display("txn level latency=%0d ipl=%0d", lat, ipl_o);

    // Table-driven IACK vectors in level mode
    for (int t = 0; t < 8; t++) begin
      wb_write(2'd1, {1'b0, tbl[t].mask_val});
      wb_write(2'd3, tbl[t].cfg);
      @(negedge clk); int_i = tbl[t].int_val;
      wait_cycles(6);
      check("tbl_ipl", ipl_o, tbl[t].exp_ipl);
      iack_start(tbl[t].lvl, delay, vec);
      check("tbl_iack_delay", delay, 2);
      check("tbl_vector", vec, tbl[t].exp_vec);
      iack_end();
      wb_read(2'd0, rd);
      check("tbl_pend_level_kept", rd, {1'b0, tbl[t].int_val});
      $display("txn tbl[%0d] int=%h mask=%h cfg=%h lvl=%0d ipl=%0d vec=%h", t,
               tbl[t].int_val, tbl[t].mask_val, tbl[t].cfg, tbl[t].lvl, ipl_o, vec);
    end

    // Randomized level-mode traffic
    for (int r = 0; r < 12; r++) begin
      ival = int'($urandom_range(0, 127));
      mval = int'($urandom_range(0, 127));
      cfg  = 8'($urandom_range(0, 255));
      lvl  = int'($urandom_range(0, 7));
      wb_write(2'd1, 8'(mval));
      wb_write(2'd3, cfg);
      @(negedge clk); int_i = 7'(ival);
      wait_cycles(6);
      check("rnd_lvl_ipl", ipl_o, model_ipl(ival & mval));
      iack_start(3'(lvl), delay, vec);
      check("rnd_lvl_delay", delay, 2);
      check("rnd_lvl_vector", vec, model_vec(ival & mval, lvl, int'(cfg)));
      iack_end();
      $display("txn rnd_level int=%h mask=%h cfg=%h lvl=%0d vec=%h", ival, mval, cfg, lvl, vec);
    end

    // Edge mode: pulse level 2, autovector service clears it
    @(negedge clk); int_i = 7'd0;
    wait_cycles(6);
    wb_write(2'd1, 8'h7F);
    wb_write(2'd2, 8'h7F);
    pulse_int(7'h02);
    wait_cycles(6);
    wb_read(2'd0, rd); check("edge_pend_set", rd, 8'h02);
    check("edge_ipl2", ipl_o, 2);
    wb_write(2'd3, 8'h81);
    iack_start(3'd2, delay, vec);
    check("auto_delay", delay, 2);
    check("auto_vector", vec, 26);
    iack_end();
    wb_read(2'd0, rd); check("edge_pend_serviced", rd, 8'h00);
    wait_cycles(3);
    check("edge_ipl_cleared", ipl_o, 0);
    $display("txn autovec lvl=2 vec=%0d", vec);

    // Vector in flight unaffected by a later higher-priority arrival
    wb_write(2'd3, 8'h40);
    pulse_int(7'h40);
    wait_cycles(6);
    iack_start(3'd7, delay, vec);
    check("vbase_delay", delay, 2);
    check("vbase_vector", vec, 8'h47);
    pulse_int(7'h20);
    wait_cycles(6);
    check("vector_held", vector_o, 8'h47);
    check("iack_ack_held", iack_ack_o, 1);
    check("ipl_new_level6", ipl_o, 6);
    iack_end();
    wb_read(2'd0, rd); check("pend_only_level6", rd, 8'h20);
    wb_write(2'd0, 8'h20);
    $display("txn vbase lvl=7 vec=%h", vec);

    // Spurious acknowledge
    wb_read(2'd0, rd); check("spur_pend_before", rd, 8'h00);
    iack_start(3'd3, delay, vec);
    check("spur_delay", delay, 2);
    check("spur_vector", vec, 24);
    iack_end();
    wb_read(2'd0, rd); check("spur_pend_after", rd, 8'h00);
    $display("txn spurious lvl=3 vec=%0d", vec);

    // Set and software clear on the same cycle: set wins
    @(negedge clk); int_i = 7'h01;
    @(negedge clk);
    wb_write(2'd0, 8'h01);
    wb_read(2'd0, rd); check("set_beats_clear", rd, 8'h01);
    @(negedge clk); int_i = 7'd0;
    wb_write(2'd1, 8'h7E);
    wait_cycles(3);
    check("masked_ipl_zero", ipl_o, 0);
    wb_read(2'd0, rd); check("masked_pend_kept", rd, 8'h01);
    $display("txn set_vs_clear pend=%h", rd);

    // Randomized edge-mode traffic against a pending-set model
    wb_write(2'd1, 8'h7F);
    wb_write(2'd0, 8'h7F);
    mdl_pend = 0;
    for (int r = 0; r < 14; r++) begin
      ival = int'($urandom_range(1, 127));
      pulse_int(7'(ival));
      mdl_pend |= ival;
      wait_cycles(4);
      if ($urandom_range(0, 1) == 1) begin
        clr = int'($urandom_range(0, 127));
        wb_write(2'd0, 8'(clr));
        mdl_pend &= ~clr;
      end
      wb_read(2'd0, rd); check("rnd_edge_pend", rd, mdl_pend);
      wait_cycles(3);
      check("rnd_edge_ipl", ipl_o, model_ipl(mdl_pend));
      cfg = 8'($urandom_range(0, 255));
      lvl = int'($urandom_range(0, 7));
      wb_write(2'd3, cfg);
      iack_start(3'(lvl), delay, vec);
      check("rnd_edge_delay", delay, 2);
      check("rnd_edge_vector", vec, model_vec(mdl_pend, lvl, int'(cfg)));
      if (lvl != 0) mdl_pend &= ~(1 << (lvl - 1));
      iack_end();
      wb_read(2'd0, rd); check("rnd_edge_pend_after", rd, mdl_pend);
      $display("txn rnd_edge pulse=%h cfg=%h lvl=%0d vec=%h pend=%h", ival, cfg, lvl, vec, rd);
    end

    // Reset during ACK
    wb_write(2'd0, 8'h7F);
    pulse_int(7'h01);
    wait_cycles(6);
    check("pre_rst_ipl", ipl_o, 1);
    iack_start(3'd3, delay, vec);
    check("pre_rst_delay", delay, 2);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_ack_iack_ack", iack_ack_o, 0);
    check("rst_ack_ipl", ipl_o, 0);
    check("rst_ack_vector", vector_o, 0);
    @(negedge clk); rst = 1'b0; iack_i = 1'b0;
    wb_read(2'd0, rd); check("rst2_pend", rd, 8'h00);
    wb_read(2'd1, rd); check("rst2_mask", rd, 8'h00);
    wb_read(2'd2, rd); check("rst2_edge", rd, 8'h00);
    wb_read(2'd3, rd); check("rst2_cfg", rd, 8'h40);
    $display("txn reset_during_ack done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m68k_irq_vector_ctrl.md
Name: m68k_irq_vector_ctrl

Overview:
Interrupt sequencer between seven peripheral interrupt lines and the 68000 core.
- Synchronises each line and detects edges; holds per-level pending, mask and trigger-mode state.
- Drives the encoded IPL to the CPU.
- Serves the CPU interrupt-acknowledge (IACK) cycle with a vector number and clears the serviced edge request.
- Configuration is by a small Wishbone slave on the system bus.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on int_i (minimum 2).
- SPURIOUS_VEC, 8'd24, vector returned when the acknowledged level has nothing pending.

Ports:
- wb_clk_i  in  1  system clock.
- wb_reset_i  in  1  reset, synchronous, active-high.
- int_i  in  7  async interrupt requests; bit n = level n+1.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  Wishbone write enable.
- wb_adr_i  in  2  register select.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data.
- wb_ack_o  out  1  Wishbone acknowledge.
- iack_i  in  1  CPU IACK cycle active (FC=7 decode).
- iack_level_i  in  3  level being acknowledged (CPU A3:A1).
- iack_ack_o  out  1  vector valid / DTACK for the IACK cycle.
- vector_o  out  8  vector number.
- ipl_o  out  3  encoded priority to the CPU, active-high, 0 = none.

Behaviour:
- Reset: ipl_o=0, iack_ack_o=0, vector_o=0, wb_ack_o=0, wb_dat_o=0. PEND=0, MASK=0 (all masked), EDGE=0, VBASE=0x40, AUTOVEC=0. FSM=IDLE.
- Sync: int_i passes through SYNC_STAGES flops to give s[6:0]. Edge detect uses the previous s.
- Pending, level mode (EDGE[n]=0): PEND[n] = s[n] every cycle; software clear has no effect.
- Pending, edge mode (EDGE[n]=1): s rising edge sets PEND[n]. Software write-1 or IACK service clears it. If a set and a clear hit the same cycle, set wins.
- Masking: eff = PEND & MASK. ipl_o is registered: the highest set bit index+1 of eff, else 0.
  - Latency from int_i edge to ipl_o is SYNC_STAGES+2 cycles.
- Registers (wb_adr_i):
  - 0 PEND: read gives PEND; write-1-to-clear, edge bits only.
  - 1 MASK: read/write bits 6:0; bit 7 reads 0.
  - 2 EDGE: read/write bits 6:0.
  - 3 CFG: bits 7:3 = VBASE[7:3], bit 0 = AUTOVEC.
- Wishbone timing: wb_ack_o is a one-cycle pulse the cycle after cyc&stb when ack is low. Back-to-back accesses take 2 cycles each. Read data is valid with ack. The write takes effect on the ack edge.
- IACK FSM:
  - IDLE: iack_i=1 → LATCH. Latch lvl = iack_level_i.
  - LATCH: lvl==0 or eff[lvl-1]==0 → vector_o = SPURIOUS_VEC. Otherwise:
    - AUTOVEC=1 → vector_o = 24+lvl.
    - AUTOVEC=0 → vector_o = {VBASE[7:3], lvl}.
    - If EDGE[lvl-1]=1, clear PEND[lvl-1].
    - Go to ACK.
  - ACK: iack_ack_o=1 and vector_o held stable while iack_i=1. When iack_i=0, drop iack_ack_o and go to IDLE.
  - iack_ack_o rises 2 cycles after iack_i is first sampled high.
- The vector is chosen from eff at LATCH time. A higher level arriving later does not alter the vector in flight.
- Reset during LATCH or ACK: FSM goes to IDLE and iack_ack_o drops in the same cycle.
- Level-mode sources are not cleared by IACK; the peripheral must deassert its line.

Decomposition:
- Shared package m68k_pkg holds:
  - register address constants REG_PEND/REG_MASK/REG_EDGE/REG_CFG;
  - IACK state enum IDLE/LATCH/ACK;
  - AUTOVEC_BASE=24 and SPURIOUS_VEC default.
- One natural sub-module: irq_sync_edge (per-line synchroniser plus rising-edge pulse), instantiated as a 7-bit vector.

Test Plan:
- Reset, MASK=0x7F, EDGE=0, drive int_i=0x14 → ipl_o=5 within SYNC_STAGES+2 cycles. Clear bit 4 → ipl_o=3.
- EDGE=0x7F, pulse int_i[1] one cycle → PEND=0x02, ipl_o=2. IACK level 2 with CFG=0x81 → vector_o=26, iack_ack_o high 2 cycles after iack_i. Afterwards PEND=0, ipl_o=0.
- CFG=0x40 (AUTOVEC=0), level 7 pending, IACK level 7 → vector_o=0x47. Raise level 6 during ACK → vector_o still 0x47.
- IACK level 3 with nothing pending → vector_o=24, ack handshake completes, no PEND change.
- Edge mode: write PEND=0x01 on the same cycle as an int_i[0] rising edge → PEND[0] stays 1. Mask bit 0 → ipl_o=0 while PEND[0] is still 1.
- Assert wb_reset_i during ACK → iack_ack_o=0 the next cycle, all registers back to reset values, ipl_o=0.
